// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: FSM state encoding,
// ALU op-code constants, datapath width and a small op-dependent helper.
package calc_pkg;

  localparam int unsigned DATA_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4
  } state_t;

  // Negation is unary, so it skips the second-operand state.
  function automatic state_t state_after_op(input logic [1:0] op);
    return (op == OP_NEG) ? S_EXEC : S_B;
  endfunction

endpackage

// File: rtl/calc_sequencer.sv
// Token-driven sequencer for an external combinational 4-bit ALU.
// Collects operand A, an operator and (unless the op is negate) operand B
// from a valid/ready token stream, drives the registered operands to the
// ALU, captures the ALU result for one cycle and presents it on a
// valid/ready result port.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   token handshake; in_is_op selects op vs digit,
//                       in_data carries the digit or the op code in [1:0]
//   alu_a/alu_b/alu_op  registered operands and op to the external ALU
//   alu_result          ALU output, captured in the execute cycle
//   res_valid/res_ready result handshake; res_data/res_op held until taken
//   err                 one-cycle pulse after a wrong-type token is accepted
//
// Optional feature: define CALC_CHAIN_EN to let an op token arriving in
// S_A reuse the last delivered result as operand A.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_op,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_op,
  output logic              err
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [1:0]          res_op_q, res_op_d;
  logic                err_q, err_d;
`ifdef CALC_CHAIN_EN
  logic                chain_q, chain_d;
`endif

  logic take;

  assign take = in_valid && in_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      res_data_q <= '0;
      res_op_q   <= OP_ADD;
      err_q      <= 1'b0;
`ifdef CALC_CHAIN_EN
      chain_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_data_q <= res_data_d;
      res_op_q   <= res_op_d;
      err_q      <= err_d;
`ifdef CALC_CHAIN_EN
      chain_q    <= chain_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;
    err_d      = 1'b0;
`ifdef CALC_CHAIN_EN
    chain_d    = chain_q;
`endif

    unique case (state_q)
      S_A: begin
        if (take) begin
          if (!in_is_op) begin
            a_d     = in_data;
            state_d = S_OP;
`ifdef CALC_CHAIN_EN
            chain_d = 1'b0;
`endif
          end else begin
`ifdef CALC_CHAIN_EN
            // Chained op: previous result becomes A, then behave as in S_OP.
            if (chain_q) begin
              a_d     = res_data_q;
              op_d    = in_data[1:0];
              state_d = state_after_op(in_data[1:0]);
            end else begin
              err_d = 1'b1;
            end
`else
            err_d = 1'b1;
`endif
          end
        end
      end
      S_OP: begin
        if (take) begin
          if (in_is_op) begin
            op_d    = in_data[1:0];
            state_d = state_after_op(in_data[1:0]);
          end else begin
            a_d = in_data;
          end
        end
      end
      S_B: begin
        if (take) begin
          if (!in_is_op) begin
            b_d     = in_data;
            state_d = S_EXEC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        res_data_d = alu_result;
        res_op_d   = op_q;
        state_d    = S_RES;
      end
      S_RES: begin
        if (res_ready) begin
          state_d = S_A;
`ifdef CALC_CHAIN_EN
          chain_d = 1'b1;
`endif
        end
      end
      default: state_d = S_A;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = !rst && ((state_q == S_A) || (state_q == S_OP) || (state_q == S_B));
    res_valid = (state_q == S_RES);
    alu_a     = a_q;
    // B may hold a stale operand from an earlier calculation; negate ignores it.
    alu_b     = (op_q == OP_NEG) ? '0 : b_q;
    alu_op    = op_q;
    res_data  = res_data_q;
    res_op    = res_op_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_is_op;
  logic [3:0] in_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [1:0] res_op;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  calc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_op   (in_is_op),
    .in_data    (in_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_op     (res_op),
    .err        (err)
  );

  // External ALU
  always_comb begin
    case (alu_op)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a | alu_b;
      default: alu_result = 4'd0 - alu_a;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_err", err, 0);
    rst = 1'b0;
  endtask

  // Offer one token; returns in the cycle after it was accepted.
  task automatic send(input logic is_op, input logic [3:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_is_op = is_op;
    in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_is_op = 1'b0;
    in_data  = 4'd0;
    if (!done) check_eq("send_timeout", 0, 1);
  endtask

  // Called in cycle N+1 after the final token; checks ALU drive, result, handshake.
  task automatic expect_result(input string tag, input logic [3:0] a, input logic [3:0] b,
                               input logic [1:0] op, input logic [3:0] res, input int hold);
    check_eq({tag, "_exec_valid"}, res_valid, 0);
    check_eq({tag, "_alu_a"}, alu_a, a);
    check_eq({tag, "_alu_b"}, alu_b, b);
    check_eq({tag, "_alu_op"}, alu_op, op);
    @(posedge clk); #1;
    check_eq({tag, "_res_valid"}, res_valid, 1);
    check_eq({tag, "_res_data"}, res_data, res);
    check_eq({tag, "_res_op"}, res_op, op);
    check_eq({tag, "_in_ready_res"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("%s_hold%0d_valid", tag, i), res_valid, 1);
      check_eq($sformatf("%s_hold%0d_data", tag, i), res_data, res);
      check_eq($sformatf("%s_hold%0d_in_ready", tag, i), in_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_eq({tag, "_after_valid"}, res_valid, 0);
    check_eq({tag, "_after_in_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_is_op  = 1'b0;
    in_data   = 4'd0;
    res_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // 3 + 4
    send(0, 4'd3); send(1, 4'd0); send(0, 4'd4);
    expect_result("add", 4'd3, 4'd4, 2'b00, 4'd7, 0);

    // 2 - 5, 9 + 9 wrap
    send(0, 4'd2); send(1, 4'd1); send(0, 4'd5);
    expect_result("sub", 4'd2, 4'd5, 2'b01, 4'hD, 0);
    send(0, 4'd9); send(1, 4'd0); send(0, 4'd9);
    expect_result("wrap", 4'd9, 4'd9, 2'b00, 4'd2, 0);

    // negate skips B; B forced to zero even though B register holds 9
    send(0, 4'd5); send(1, 4'd3);
    expect_result("neg", 4'd5, 4'd0, 2'b11, 4'hB, 0);

    // op first after reset: error pulse, stays in S_A
    do_reset();
    send(1, 4'd2);
    check_eq("op_first_err", err, 1);
    check_eq("op_first_ready", in_ready, 1);
    @(posedge clk); #1;
    check_eq("op_first_err_clear", err, 0);
    send(0, 4'd6); send(1, 4'd2); send(0, 4'd1);
    expect_result("or_hold", 4'd6, 4'd1, 2'b10, 4'd7, 3);

    // chaining after 0111 delivered
    send(1, 4'd0);
`ifdef CALC_CHAIN_EN
    check_eq("chain_no_err", err, 0);
    send(0, 4'd1);
    expect_result("chain", 4'd7, 4'd1, 2'b00, 4'd8, 0);
`else
    check_eq("nochain_err", err, 1);
    send(0, 4'd1); send(1, 4'd0); send(0, 4'd1);
    expect_result("nochain", 4'd1, 4'd1, 2'b00, 4'd2, 0);
`endif

    // digit in S_OP overwrites A without error
    send(0, 4'd7); send(0, 4'd3);
    check_eq("overwrite_no_err", err, 0);
    send(1, 4'd0); send(0, 4'd2);
    expect_result("overwrite", 4'd3, 4'd2, 2'b00, 4'd5, 0);

    // op token in S_B: error, op unchanged, stays in S_B
    send(0, 4'd1); send(1, 4'd0); send(1, 4'd1);
    check_eq("sb_op_err", err, 1);
    send(0, 4'd2);
    expect_result("sb_op", 4'd1, 4'd2, 2'b00, 4'd3, 0);

    // reset during S_EXEC discards the result
    send(0, 4'd3); send(1, 4'd0); send(0, 4'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("exec_rst_valid", res_valid, 0);
    check_eq("exec_rst_alu_a", alu_a, 0);
    check_eq("exec_rst_alu_b", alu_b, 0);
    check_eq("exec_rst_alu_op", alu_op, 0);
    check_eq("exec_rst_res_data", res_data, 0);
    check_eq("exec_rst_res_op", res_op, 0);
    check_eq("exec_rst_err", err, 0);
    check_eq("exec_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("exec_rst_no_valid%0d", i), res_valid, 0);
    end
    res_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
